// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch queue between IF and ID. Entries hold {PC, instruction}
// and leave in the order they were fetched. A branch redirect (flush) drops
// every queued entry at once. almost_full is intended to stall the PC.
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN):
//   When defined, an entry presented to an empty queue is forwarded to the
//   dequeue side in the same cycle. If ID also consumes it that cycle, the
//   entry is never written to storage. When undefined there is no
//   combinational path from enq_* to deq_*, and entries appear one cycle
//   after they are accepted.
//
// Parameters:
//   DATA_W  width of the PC and instruction fields
//   DEPTH   number of entries, power of two, >= 2
//   CNT_W   derived width of count ($clog2(DEPTH)+1)
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-low reset
//   flush        in   branch redirect, discards all entries
//   enq_valid    in   IF presents an entry
//   enq_pc       in   PC of the fetched instruction
//   enq_instr    in   fetched instruction word
//   enq_ready    out  queue accepts an entry this cycle
//   deq_valid    out  head entry available to ID
//   deq_pc       out  PC of the head entry
//   deq_instr    out  instruction of the head entry
//   deq_ready    in   ID consumes the head entry
//   count        out  current occupancy, 0..DEPTH
//   almost_full  out  count >= DEPTH-1
// ----------------------------------------------------------------------------
module fetch_queue #(
   parameter int  DATA_W = 32,
   parameter int  DEPTH  = 4,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              enq_valid,
   input  logic [DATA_W-1:0] enq_pc,
   input  logic [DATA_W-1:0] enq_instr,
   output logic              enq_ready,
   output logic              deq_valid,
   output logic [DATA_W-1:0] deq_pc,
   output logic [DATA_W-1:0] deq_instr,
   input  logic              deq_ready,
   output logic [CNT_W-1:0]  count,
   output logic              almost_full
);

   localparam int               PTR_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - 1);

   // Storage: never reset, written only on an accepted enqueue
   logic [DATA_W-1:0] pc_mem_q    [DEPTH];
   logic [DATA_W-1:0] instr_mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic empty;
   logic bypass_take;   // entry forwarded and consumed without being stored
   logic do_enq;
   logic do_deq;

   assign empty       = (count_q == '0);
   assign count       = count_q;
   assign almost_full = (count_q >= AF_CNT);
   // A full queue refuses entries even if it is draining this cycle
   assign enq_ready   = (count_q != FULL_CNT) && reset;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass;

   assign bypass      = empty && enq_valid && !flush && reset;
   assign bypass_take = bypass && deq_ready;
   assign deq_valid   = (!empty && !flush && reset) || bypass;
   assign deq_pc      = bypass ? enq_pc    : pc_mem_q[rd_ptr_q];
   assign deq_instr   = bypass ? enq_instr : instr_mem_q[rd_ptr_q];
`else
   assign bypass_take = 1'b0;
   assign deq_valid   = !empty && !flush && reset;
   assign deq_pc      = pc_mem_q[rd_ptr_q];
   assign deq_instr   = instr_mem_q[rd_ptr_q];
`endif

   // A bypassed-and-consumed entry is neither pushed nor popped
   assign do_enq = enq_valid && enq_ready && !flush && !bypass_take;
   assign do_deq = deq_valid && deq_ready && !flush && !bypass_take;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Power-of-two depth: pointers wrap naturally at DEPTH-1 -> 0
         if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_enq) begin
         pc_mem_q[wr_ptr_q]    <= enq_pc;
         instr_mem_q[wr_ptr_q] <= enq_instr;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue (DATA_W=32, DEPTH=4). Inputs are driven at
// the falling edge; outputs are sampled 1ns later, well away from the rising
// edge. Each instruction word is derived from its PC so that both fields of
// every entry can be checked.
// ----------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              enq_valid;
   logic [DATA_W-1:0] enq_pc;
   logic [DATA_W-1:0] enq_instr;
   logic              enq_ready;
   logic              deq_valid;
   logic [DATA_W-1:0] deq_pc;
   logic [DATA_W-1:0] deq_instr;
   logic              deq_ready;
   logic [CNT_W-1:0]  count;
   logic              almost_full;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   fetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .enq_valid   (enq_valid),
      .enq_pc      (enq_pc),
      .enq_instr   (enq_instr),
      .enq_ready   (enq_ready),
      .deq_valid   (deq_valid),
      .deq_pc      (deq_pc),
      .deq_instr   (deq_instr),
      .deq_ready   (deq_ready),
      .count       (count),
      .almost_full (almost_full)
   );

   function automatic logic [DATA_W-1:0] instr_of(input logic [DATA_W-1:0] pc);
      return {~pc[15:0], pc[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Apply one cycle of inputs at the falling edge, then settle for sampling
   task automatic cyc(input logic ev, input logic [DATA_W-1:0] pc,
                      input logic dr, input logic fl, input logic rs);
      @(negedge clk);
      enq_valid = ev;
      enq_pc    = pc;
      enq_instr = instr_of(pc);
      deq_ready = dr;
      flush     = fl;
      reset     = rs;
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_pc = '0;
      enq_instr = '0; deq_ready = 1'b0;
      repeat (2) cyc(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
      total_cnt++;
      if (enq_ready !== 1'b0) $display("FAIL rst_enq_ready: got %b want 0", enq_ready);
      else pass_cnt++;
      total_cnt++;
      if (deq_valid !== 1'b0) $display("FAIL rst_deq_valid: got %b want 0", deq_valid);
      else pass_cnt++;
      idle();
      total_cnt++;
      if (count !== 0) $display("FAIL rel_count: got %0d want 0", count);
      else pass_cnt++;
      total_cnt++;
      if (almost_full !== 1'b0) $display("FAIL rel_almost_full: got %b want 0", almost_full);
      else pass_cnt++;
      total_cnt++;
      if (enq_ready !== 1'b1) $display("FAIL rel_enq_ready: got %b want 1", enq_ready);
      else pass_cnt++;
      total_cnt++;
      if (deq_valid !== 1'b0) $display("FAIL rel_deq_valid: got %b want 0", deq_valid);
      else pass_cnt++;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b1);
         // state before this cycle's edge holds i entries
         total_cnt++;
         if (count !== CNT_W'(i)) $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i);
         else pass_cnt++;
         total_cnt++;
         if (almost_full !== (i >= 3)) $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i >= 3));
         else pass_cnt++;
      end
      idle();
      total_cnt++;
      if (count !== 4) $display("FAIL full_count: got %0d want 4", count);
      else pass_cnt++;
      total_cnt++;
      if (enq_ready !== 1'b0) $display("FAIL full_enq_ready: got %b want 0", enq_ready);
      else pass_cnt++;
      total_cnt++;
      if (almost_full !== 1'b1) $display("FAIL full_af: got %b want 1", almost_full);
      else pass_cnt++;
      total_cnt++;
      if (deq_valid !== 1'b1 || deq_pc !== 32'h0) $display("FAIL full_head: got v=%b pc=%h want v=1 pc=0", deq_valid, deq_pc);
      else pass_cnt++;
   endtask

   task automatic test_drain_wrap();
      logic [DATA_W-1:0] exp_pc [6];
      exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
      for (int k = 0; k < 6; k++) begin
         if (k == 1)      cyc(1'b1, 32'h10, 1'b1, 1'b0, 1'b1);
         else if (k == 2) cyc(1'b1, 32'h14, 1'b1, 1'b0, 1'b1);
         else             cyc(1'b0, 32'h0,  1'b1, 1'b0, 1'b1);
         if (k == 0) begin
            total_cnt++;
            if (enq_ready !== 1'b0) $display("FAIL full_deq_enq_ready: got %b want 0", enq_ready);
            else pass_cnt++;
         end
         total_cnt++;
         if (deq_valid !== 1'b1 || deq_pc !== exp_pc[k] || deq_instr !== instr_of(exp_pc[k]))
            $display("FAIL drain_order[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                     k, deq_valid, deq_pc, deq_instr, exp_pc[k], instr_of(exp_pc[k]));
         else pass_cnt++;
      end
      idle();
      total_cnt++;
      if (count !== 0 || deq_valid !== 1'b0) $display("FAIL drain_empty: got count=%0d v=%b want 0/0", count, deq_valid);
      else pass_cnt++;
   endtask

   task automatic test_flush();
      cyc(1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'h34, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'h38, 1'b1, 1'b1, 1'b1);
      total_cnt++;
      if (deq_valid !== 1'b0) $display("FAIL flush_deq_valid: got %b want 0", deq_valid);
      else pass_cnt++;
      idle();
      total_cnt++;
      if (count !== 0) $display("FAIL flush_count: got %0d want 0", count);
      else pass_cnt++;
      cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
      idle();
      total_cnt++;
      if (count !== 1 || deq_pc !== 32'h40) $display("FAIL post_flush_head: got count=%0d pc=%h want 1/40", count, deq_pc);
      else pass_cnt++;
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      idle();
   endtask

   task automatic test_reset_mid();
      cyc(1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'h54, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'h58, 1'b0, 1'b0, 1'b1);
      idle();
      total_cnt++;
      if (count !== 3) $display("FAIL mid_pre_count: got %0d want 3", count);
      else pass_cnt++;
      cyc(1'b1, 32'h5C, 1'b1, 1'b1, 1'b0);
      total_cnt++;
      if (enq_ready !== 1'b0 || deq_valid !== 1'b0) $display("FAIL mid_rst_outputs: got rdy=%b v=%b want 0/0", enq_ready, deq_valid);
      else pass_cnt++;
      idle();
      total_cnt++;
      if (count !== 0 || enq_ready !== 1'b1 || deq_valid !== 1'b0 || almost_full !== 1'b0)
         $display("FAIL mid_after: got count=%0d rdy=%b v=%b af=%b want 0/1/0/0", count, enq_ready, deq_valid, almost_full);
      else pass_cnt++;
   endtask

   task automatic test_bypass();
      cyc(1'b1, 32'h20, 1'b1, 1'b0, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
      total_cnt++;
      if (deq_valid !== 1'b1 || deq_pc !== 32'h20 || deq_instr !== instr_of(32'h20))
         $display("FAIL byp_same_cycle: got v=%b pc=%h want v=1 pc=20", deq_valid, deq_pc);
      else pass_cnt++;
      idle();
      total_cnt++;
      if (count !== 0 || deq_valid !== 1'b0) $display("FAIL byp_not_stored: got count=%0d v=%b want 0/0", count, deq_valid);
      else pass_cnt++;
`else
      total_cnt++;
      if (deq_valid !== 1'b0) $display("FAIL nobyp_same_cycle: got v=%b want 0", deq_valid);
      else pass_cnt++;
      idle();
      total_cnt++;
      if (count !== 1 || deq_valid !== 1'b1 || deq_pc !== 32'h20)
         $display("FAIL nobyp_next: got count=%0d v=%b pc=%h want 1/1/20", count, deq_valid, deq_pc);
      else pass_cnt++;
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      idle();
`endif
   endtask

   task automatic test_back_to_back();
      cyc(1'b1, 32'h60, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'h64, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 32'(32'h68 + 4 * k), 1'b1, 1'b0, 1'b1);
         total_cnt++;
         if (count !== 2 || deq_pc !== 32'(32'h60 + 4 * k) || deq_instr !== instr_of(32'(32'h60 + 4 * k)))
            $display("FAIL b2b[%0d]: got count=%0d pc=%h want 2/%h", k, count, deq_pc, 32'(32'h60 + 4 * k));
         else pass_cnt++;
      end
      idle();
      total_cnt++;
      if (count !== 2 || deq_pc !== 32'h80) $display("FAIL b2b_end: got count=%0d pc=%h want 2/80", count, deq_pc);
      else pass_cnt++;
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      total_cnt++;
      if (deq_pc !== 32'h84) $display("FAIL b2b_tail: got pc=%h want 84", deq_pc);
      else pass_cnt++;
      idle();
      total_cnt++;
      if (count !== 0) $display("FAIL b2b_drained: got count=%0d want 0", count);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain_wrap();
      test_flush();
      test_reset_mid();
      test_bypass();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_W, default 32, width of the PC and instruction fields.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, >= 2.
REQ-003 Derived CNT_W = clog2(DEPTH)+1, width of count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 flush  input  1  branch redirect (PCSrc); discards all queued entries.
REQ-007 enq_valid  input  1  IF presents a fetched entry.
REQ-008 enq_pc  input  DATA_W  PC of the fetched instruction.
REQ-009 enq_instr  input  DATA_W  fetched instruction word.
REQ-010 enq_ready  output  1  queue accepts an entry this cycle.
REQ-011 deq_valid  output  1  head entry is available to ID.
REQ-012 deq_pc  output  DATA_W  PC of the head entry.
REQ-013 deq_instr  output  DATA_W  instruction of the head entry.
REQ-014 deq_ready  input  1  ID consumes the head entry (IF_ID_write).
REQ-015 count  output  CNT_W  current occupancy, 0..DEPTH.
REQ-016 almost_full  output  1  count >= DEPTH-1; used to drive PC_write low.

Function
REQ-017 Enqueue SHALL occur when enq_valid && enq_ready && !flush at a rising edge; dequeue when deq_valid && deq_ready && !flush.
REQ-018 enq_ready SHALL equal (count != DEPTH) && reset; it does not depend on deq_ready (a full queue accepts nothing, even if dequeuing in the same cycle).
REQ-019 deq_valid SHALL equal (count != 0) && !flush && reset; deq_pc/deq_instr SHALL show the head entry combinationally from storage and are don't-care when deq_valid = 0.
REQ-020 Entries SHALL leave in enqueue order; write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 With simultaneous enqueue and dequeue, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 Latency (without bypass) SHALL be one cycle: an entry enqueued at edge N is visible on deq_* after edge N.
REQ-023 Flush SHALL take priority over all traffic. At that edge, both pointers and count SHALL go to 0, and any same-cycle enqueue or dequeue SHALL be dropped.
REQ-024 While deq_valid = 1 and deq_ready = 0, deq_pc/deq_instr SHALL stay stable until dequeued or flushed.
REQ-025 Storage contents SHALL be written only on an accepted enqueue; no other event modifies them.

Reset
REQ-026 When reset = 0 at a rising edge: write pointer, read pointer and count SHALL be set to 0; storage is not cleared.
REQ-027 While reset = 0: enq_ready = 0 and deq_valid = 0. In the first cycle after release: count = 0, almost_full = 0, enq_ready = 1.
REQ-028 Reset asserted mid-operation SHALL discard all entries exactly as flush does; reset has priority over flush.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN:
- When defined: if count = 0, enq_valid = 1 and !flush, then deq_valid = 1 and deq_pc/deq_instr = enq_pc/enq_instr in the same cycle.
- If deq_ready = 1 in that cycle, the entry SHALL NOT be stored and count stays 0.
- When undefined: no combinational path from enq_* to deq_*; REQ-022 latency applies.

Verification
REQ-030 Reset release, then 4 enqueues (pc 0x00,0x04,0x08,0x0C) with deq_ready = 0 -> count = 4, enq_ready = 0, almost_full = 1 after the 3rd enqueue; deq_pc = 0x00.
REQ-031 Full queue, deq_ready = 1 for 6 cycles while enqueuing pc 0x10,0x14 -> order 0x00,0x04,0x08,0x0C,0x10,0x14; pointers wrap; count returns to 0.
REQ-032 count = 2, flush = 1 with enq_valid = 1 and deq_ready = 1 -> no transfer, deq_valid = 0 that cycle, count = 0 the next cycle.
REQ-033 count = 3, reset = 0 for one cycle -> enq_ready = 0 and deq_valid = 0 during reset; count = 0 and enq_ready = 1 afterwards.
REQ-034 count = 0, enq pc 0x20 with deq_ready = 1 -> with FETCH_QUEUE_BYPASS_EN: deq_pc = 0x20 in the same cycle, count stays 0; without it: deq_valid = 1 on the next cycle, count = 1.
REQ-035 count = 2, enq and deq in the same cycle for 8 cycles -> count stays 2 and no entry is lost or duplicated.
